// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier: one partial-product row per clock,
// with a start/busy/done handshake. Results match the combinational array multiplier.
module shift_add_mult_ctrl #(
    parameter int M_WIDTH = 2,
    parameter int Q_WIDTH = 3,
    localparam int SW = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1,
    localparam int PW = M_WIDTH + Q_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [M_WIDTH-1:0] i_m_in,
    input  logic [Q_WIDTH-1:0] i_q_in,
    output logic               o_busy,
    output logic               o_done,
    output logic [SW-1:0]      o_step,
    output logic [PW-1:0]      o_product
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [SW-1:0] LAST_STEP = SW'(Q_WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [M_WIDTH-1:0] r_m;
    logic [Q_WIDTH-1:0] r_q;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_product;
    logic [SW-1:0]      r_step;
    logic               r_busy;
    logic               r_done;

    logic               w_last;
    logic [M_WIDTH-1:0] w_pp_row;
    logic [PW-1:0]      w_pp;
    logic [PW-1:0]      w_acc_next;

    assign w_last     = (r_step == LAST_STEP);
    assign w_pp_row   = r_m & {M_WIDTH{r_q[r_step]}};
    assign w_pp       = {{Q_WIDTH{1'b0}}, w_pp_row} << r_step;
    assign w_acc_next = r_acc + w_pp;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_RUN;
            S_RUN:   if (w_last)  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // busy/done come straight from flops loaded with the next-state decode,
    // so they stay aligned with the state register and cannot glitch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (w_state_next == S_DONE);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m       <= '0;
            r_q       <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_step    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_m    <= i_m_in;
                        r_q    <= i_q_in;
                        r_acc  <= '0;
                        r_step <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_product <= w_acc_next;
                        r_step    <= '0;
                    end else begin
                        r_step <= r_step + SW'(1);
                    end
                end
                default: begin
                    r_step <= '0;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_step    = r_step;
    assign o_product = r_product;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl (default 2x3): vector table, exhaustive
// sweep against a ripple-array reference, and hand-written handshake/reset sequences.
module tb_shift_add_mult_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] m_in;
    logic [2:0] q_in;
    logic       busy;
    logic       done;
    logic [1:0] step;
    logic [4:0] product;

    int n_vec;
    int n_fail;
    int last_p;

    shift_add_mult_ctrl #(.M_WIDTH(2), .Q_WIDTH(3)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_m_in    (m_in),
        .i_q_in    (q_in),
        .o_busy    (busy),
        .o_done    (done),
        .o_step    (step),
        .o_product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] m;
        logic [2:0] q;
        logic [4:0] p;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Gate-level style 2x3 array: AND partial products summed with explicit full adders.
    function automatic int array_mult(input logic [1:0] a, input logic [2:0] b);
        logic [4:0] r;
        logic       pp00, pp10, pp01, pp11, pp02, pp12;
        logic       s1, c1, s2, c2, s3, c3, s4, c4;
        pp00 = a[0] & b[0]; pp10 = a[1] & b[0];
        pp01 = a[0] & b[1]; pp11 = a[1] & b[1];
        pp02 = a[0] & b[2]; pp12 = a[1] & b[2];
        s1 = pp10 ^ pp01;        c1 = pp10 & pp01;
        s2 = pp11 ^ c1;          c2 = pp11 & c1;
        s3 = s2 ^ pp02;          c3 = s2 & pp02;
        s4 = pp12 ^ c2 ^ c3;     c4 = (pp12 & c2) | (pp12 & c3) | (c2 & c3);
        r = {c4, s4, s3, s1, pp00};
        return int'(r);
    endfunction

    // Issue one operation from IDLE and follow it to completion, checking the handshake.
    task automatic do_op(input logic [1:0] m, input logic [2:0] q, input int exp, input string tag);
        int n;
        int dones;
        @(negedge clk);
        start = 1'b1; m_in = m; q_in = q;
        @(posedge clk); #1;
        start = 1'b0;
        m_in = ~m;
        check({tag, " busy_after_accept"}, int'(busy), 1);
        check({tag, " step0"}, int'(step), 0);
        n = 0;
        dones = 0;
        while (n < 8 && !done) begin
            check({tag, " product_held"}, int'(product), last_p);
            @(posedge clk); #1;
            n++;
            if (!done) check({tag, " step_count"}, int'(step), n);
            check({tag, " busy_run"}, int'(busy), 1);
        end
        check({tag, " latency"}, n, 3);
        check({tag, " product"}, int'(product), exp);
        check({tag, " step_done"}, int'(step), 0);
        @(posedge clk); #1;
        check({tag, " idle_busy"}, int'(busy), 0);
        check({tag, " idle_done"}, int'(done), 0);
        last_p = exp;
    endtask

    initial begin
        vec_t tbl[6];
        int dones;
        n_vec = 0; n_fail = 0; last_p = 0;
        rst = 1'b1; start = 1'b0; m_in = '0; q_in = '0;

        tbl[0] = '{m: 2'd3, q: 3'd7, p: 5'd21};
        tbl[1] = '{m: 2'd2, q: 3'd5, p: 5'd10};
        tbl[2] = '{m: 2'd1, q: 3'd6, p: 5'd6};
        tbl[3] = '{m: 2'd0, q: 3'd7, p: 5'd0};
        tbl[4] = '{m: 2'd3, q: 3'd0, p: 5'd0};
        tbl[5] = '{m: 2'd2, q: 3'd3, p: 5'd6};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset step", int'(step), 0);
        check("reset product", int'(product), 0);

        // Back-to-back: each do_op ends mid-IDLE, so the next accept lands on the first IDLE edge.
        for (int i = 0; i < 6; i++)
            do_op(tbl[i].m, tbl[i].q, int'(tbl[i].p), $sformatf("tbl%0d", i));

        // Held start: re-accepted only once back in IDLE, operand changes in RUN ignored.
        @(negedge clk);
        start = 1'b1; m_in = 2'd1; q_in = 3'd3;
        @(posedge clk); #1;
        dones = 0;
        m_in = 2'd3;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (n == 3) check("hold product", int'(product), 3);
            if (n == 4) check("hold idle busy", int'(busy), 0);
        end
        check("hold single done", dones, 1);
        @(posedge clk); #1;
        start = 1'b0;
        check("hold reaccept busy", int'(busy), 1);
        for (int n = 0; n < 8 && !done; n++) begin
            @(posedge clk); #1;
        end
        check("hold second product", int'(product), 9);
        @(posedge clk); #1;
        last_p = 9;

        // Reset mid-run aborts with no done pulse and clears product.
        do_op(2'd3, 3'd7, 21, "pre_rst");
        @(negedge clk);
        start = 1'b1; m_in = 2'd2; q_in = 3'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort product", int'(product), 0);
        check("abort step", int'(step), 0);
        dones = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        check("abort stays idle", dones, 0);
        last_p = 0;
        do_op(2'd1, 3'd1, 1, "post_rst");

        // Exhaustive sweep against m*q and the gate-level array.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 8; b++) begin
                do_op(2'(a), 3'(b), a * b, $sformatf("exh%0dx%0d", a, b));
                check($sformatf("array%0dx%0d", a, b), int'(product), array_mult(2'(a), 3'(b)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
